// File: rtl/qab_response_checker_pkg.sv
// Shared definitions for the QAB response checker: FSM encoding, parameter
// defaults and a small decode helper.
package qab_response_checker_pkg;

  localparam int SETTLE_CYCLES_DEF = 4;
  localparam int ERR_W_DEF         = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_JUDGE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // One-hot flag for a sampled {A,B,C} combination.
  function automatic logic [7:0] combo_onehot(input logic [2:0] combo);
    return 8'b1 << combo;
  endfunction

endpackage

// File: rtl/qab_response_checker_stable_timer.sv
// Counts consecutive cycles in which the sampled stimulus has not changed.
// stable is high once SETTLE_CYCLES stable cycles have been seen, and drops
// on the first cycle the value differs from the previous one.
module stable_timer
  import qab_response_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [2:0] value,
  output logic       stable
);

  localparam logic [3:0] CNT_TC = 4'(SETTLE_CYCLES - 1);

  logic [2:0] prev_q;
  logic [3:0] cnt_q, cnt_d;
  logic       same;

  assign same   = (value == prev_q);
  assign stable = same && (cnt_q == CNT_TC);

  // Up-count on stable cycles, restart on any change; hold at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !same) begin
      cnt_d = 4'd0;
    end else if (cnt_q != CNT_TC) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Previous-value register and counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 3'd0;
      cnt_q  <= 4'd0;
    end else begin
      prev_q <= value;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/qab_response_checker.sv
// Checks a 3-input block under test against a golden truth table, judging
// each input combination once the stimulus has settled.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start after reset
//   ST_SETTLE | waiting for SETTLE_CYCLES stable sampled cycles
//   ST_JUDGE  | one cycle: compare Q with the truth table, mark combination
//   ST_HOLD   | judged; waiting for the stimulus to change
//   ST_DONE   | all 8 combinations judged; results frozen until start
module qab_response_checker
  import qab_response_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int ERR_W         = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             Q,
  input  logic [7:0]       expected,
  output logic             busy,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       seen,
  output logic             done
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       abc_q;
  logic             q_q;
  logic             mismatch_q, mismatch_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [7:0]       seen_q, seen_d;
  logic             tmr_clear;
  logic             stable;

  stable_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_stable_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .value (abc_q),
    .stable(stable)
  );

  // Next-state and result logic; start restarts the run from any state.
  always_comb begin
    state_d    = state_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    seen_d     = seen_q;
    tmr_clear  = 1'b0;
    if (start) begin
      state_d   = ST_SETTLE;
      err_d     = '0;
      seen_d    = 8'h00;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (stable) state_d = ST_JUDGE;
        end
        ST_JUDGE: begin
          seen_d = seen_q | combo_onehot(abc_q);
          if (q_q != expected[abc_q]) begin
            mismatch_d = 1'b1;
            if (err_q != ERR_MAX) err_d = err_q + ERR_ONE;
          end
          state_d = (seen_d == 8'hFF) ? ST_DONE : ST_HOLD;
        end
        ST_HOLD: begin
          // The timer sits at terminal count while the stimulus is held, so
          // stable dropping is exactly the first sampled change of {A,B,C}.
          if (!stable) begin
            state_d   = ST_SETTLE;
            tmr_clear = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sample stage and FSM/result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      abc_q      <= 3'd0;
      q_q        <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      seen_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      abc_q      <= {A, B, C};
      q_q        <= Q;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      seen_q     <= seen_d;
    end
  end

  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_JUDGE) || (state_q == ST_HOLD);
  assign done      = (state_q == ST_DONE);
  assign mismatch  = mismatch_q;
  assign err_count = err_q;
  assign seen      = seen_q;

endmodule

// File: tb/tb_qab_response_checker.sv
// Bench for qab_response_checker: segment-level reference model feeding a
// scoreboard of expected mismatch pulses, checked by an independent monitor.
module tb_qab_response_checker;

  logic       clk = 1'b0;
  logic       rst, start, A, B, C, Q;
  logic [7:0] expected;
  logic       busy, mismatch, done;
  logic [3:0] err_count;
  logic [7:0] seen;

  qab_response_checker #(
    .SETTLE_CYCLES(4),
    .ERR_W        (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .C        (C),
    .Q        (Q),
    .expected (expected),
    .busy     (busy),
    .mismatch (mismatch),
    .err_count(err_count),
    .seen     (seen),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int err;
    int seen;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   pulses = 0;
  logic mm_prev = 1'b0;

  // reference model state (one judgement per settled segment)
  logic [7:0] m_seen;
  int         m_err;
  bit         m_done;
  bit         m_first;
  logic [2:0] m_last;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every mismatch pulse must be expected, one cycle wide, and
  // show the error count / seen set predicted for that judgement.
  always @(negedge clk) begin
    if (mismatch === 1'b1) begin
      exp_t e;
      pulses++;
      chk("mm_width", int'(mm_prev), 0);
      chk("mm_expected", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("mm_err", int'(err_count), e.err);
        chk("mm_seen", int'(seen), e.seen);
      end
    end
    mm_prev = (mismatch === 1'b1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic qv);
    {A, B, C} = c;
    Q = qv;
  endtask

  task automatic model_judge(input logic [2:0] c, input logic qv);
    if (m_done) return;
    m_seen = m_seen | (8'b1 << c);
    if (qv != expected[c]) begin
      if (m_err < 15) m_err++;
      sb_q.push_back('{m_err, int'(m_seen)});
    end
    if (m_seen == 8'hFF) m_done = 1'b1;
  endtask

  // Hold a combination for dwell cycles (dwell >= 8 always settles).
  task automatic seg(input logic [2:0] c, input logic qv, input int dwell);
    drive(c, qv);
    if (m_first || c != m_last) model_judge(c, qv);
    m_first = 1'b0;
    m_last  = c;
    tick(dwell);
  endtask

  // Pulse start together with the first combination; returns one cycle
  // after the start edge so the caller can inspect the restart.
  task automatic run_start(input logic [2:0] c, input logic qv);
    m_seen  = 8'h00;
    m_err   = 0;
    m_done  = 1'b0;
    m_first = 1'b1;
    drive(c, qv);
    start = 1'b1;
    model_judge(c, qv);
    m_first = 1'b0;
    m_last  = c;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_state(input string tag, input bit exp_busy);
    chk({tag, ".seen"}, int'(seen), int'(m_seen));
    chk({tag, ".err"}, int'(err_count), m_err);
    chk({tag, ".done"}, int'(done), int'(m_done));
    chk({tag, ".busy"}, int'(busy), int'(exp_busy));
    chk({tag, ".pending"}, sb_q.size(), 0);
  endtask

  initial begin
    int         p0;
    logic [2:0] c;

    rst = 1'b1; start = 1'b0; expected = 8'hE8;
    drive(3'd0, 1'b0);
    m_seen = 8'h00; m_err = 0; m_done = 1'b0; m_first = 1'b1; m_last = 3'd0;

    // reset values
    tick(3);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.seen", int'(seen), 0);
    chk("rst.err", int'(err_count), 0);
    chk("rst.mismatch", int'(mismatch), 0);
    rst = 1'b0;
    tick(5);
    chk("idle.busy", int'(busy), 0);

    // full walk, all correct
    p0 = pulses;
    run_start(3'd0, expected[0]);
    tick(19);
    for (int i = 1; i < 8; i++) seg(3'(i), expected[i], 20);
    check_state("walk_ok", 1'b0);
    chk("walk_ok.done_abs", int'(done), 1);
    chk("walk_ok.pulses", pulses - p0, 0);

    // restart from DONE, then walk with 101 wrong
    p0 = pulses;
    run_start(3'd0, expected[0]);
    chk("restart.seen", int'(seen), 0);
    chk("restart.err", int'(err_count), 0);
    chk("restart.done", int'(done), 0);
    chk("restart.busy", int'(busy), 1);
    tick(19);
    for (int i = 1; i < 8; i++) seg(3'(i), (i == 5) ? ~expected[i] : expected[i], 20);
    check_state("walk_101", 1'b0);
    chk("walk_101.err_abs", int'(err_count), 1);
    chk("walk_101.pulses", pulses - p0, 1);

    // stimulus toggling every 3 cycles never settles
    p0 = pulses;
    c = 3'd0;
    for (int i = 0; i < 12; i++) begin
      drive(c, expected[c]);
      if (i == 0) start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(2);
      c = c + 3'd1;
    end
    chk("toggle.seen", int'(seen), 0);
    chk("toggle.busy", int'(busy), 1);
    chk("toggle.done", int'(done), 0);
    chk("toggle.pulses", pulses - p0, 0);

    // inverted Q on 20 re-judgements saturates the error counter
    expected = 8'($urandom);
    run_start(3'd3, ~expected[3]);
    tick(7);
    for (int i = 1; i < 20; i++) begin
      c = (i % 2 == 1) ? 3'd5 : 3'd3;
      seg(c, ~expected[c], 8);
    end
    check_state("sat", 1'b1);
    chk("sat.err_abs", int'(err_count), 15);

    // reset during the settle of the fifth combination
    expected = 8'hE8;
    run_start(3'd0, expected[0]);
    tick(9);
    seg(3'd1, ~expected[1], 10);
    seg(3'd2, expected[2], 10);
    seg(3'd3, expected[3], 10);
    chk("pre_rst.err", int'(err_count), 1);
    drive(3'd4, expected[4]);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_seen = 8'h00; m_err = 0; m_done = 1'b0;
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.mismatch", int'(mismatch), 0);
    chk("midrst.err", int'(err_count), 0);
    chk("midrst.seen", int'(seen), 0);
    chk("midrst.done", int'(done), 0);
    for (int i = 0; i < 4; i++) begin
      drive(3'($urandom), 1'($urandom));
      tick(10);
    end
    check_state("after_rst", 1'b0);

    // randomized runs against the segment model
    for (int r = 0; r < 6; r++) begin
      int nseg;
      expected = 8'($urandom);
      nseg = $urandom_range(6, 20);
      c = 3'($urandom);
      run_start(c, ($urandom_range(0, 3) == 0) ? ~expected[c] : expected[c]);
      tick($urandom_range(7, 13));
      for (int s = 0; s < nseg; s++) begin
        c = 3'($urandom);
        seg(c, ($urandom_range(0, 3) == 0) ? ~expected[c] : expected[c], $urandom_range(8, 14));
      end
      check_state($sformatf("rand%0d", r), !m_done);
    end

    chk("final.pending", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qab_response_checker.md
QAB_RESPONSE_CHECKER -- requirements
Module: qab_response_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning the number of consecutive stable sampled cycles required before Q is judged (legal range 1..15).
REQ-002 SHALL have parameter ERR_W, default 4, meaning the width of the error counter.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that arms a new check run.
REQ-006 SHALL have ports A, B, C  input  1 each  stimulus bits driven to the block under test.
REQ-007 SHALL have port Q  input  1  response of the block under test.
REQ-008 SHALL have port expected  input  8  golden truth table; bit index = {A,B,C}.
REQ-009 SHALL have port busy  output  1  high while a run is in progress.
REQ-010 SHALL have port mismatch  output  1  one-cycle pulse on a failed judgement.
REQ-011 SHALL have port err_count  output  ERR_W  count of mismatches, saturating.
REQ-012 SHALL have port seen  output  8  bit i set once combination i has been judged.
REQ-013 SHALL have port done  output  1  high once all 8 combinations have been judged.

Function
REQ-014 SHALL register {A,B,C} and Q into a sample stage each cycle; all decisions SHALL use the registered values.
REQ-015 SHALL implement states IDLE, SETTLE, JUDGE, HOLD, DONE.
REQ-016 IDLE->SETTLE on start; stable counter cleared; seen and err_count cleared on the same edge.
REQ-017 In SETTLE, the counter SHALL increment each cycle the registered {A,B,C} equals the previous cycle's value, and SHALL clear to 0 on any change.
REQ-018 SETTLE->JUDGE when the counter reaches SETTLE_CYCLES-1 while inputs are stable, giving SETTLE_CYCLES stable cycles in total.
REQ-019 In JUDGE (exactly one cycle), the block SHALL compare the registered Q with expected[{A,B,C}], set seen[{A,B,C}], and pulse mismatch if they differ.
REQ-020 On a mismatch, err_count SHALL increment and SHALL saturate at 2^ERR_W-1 without wrapping.
REQ-021 Re-judging an already-seen combination SHALL be judged and counted again; seen SHALL be unchanged.
REQ-022 JUDGE->DONE if seen becomes 8'hFF; otherwise JUDGE->HOLD.
REQ-023 HOLD->SETTLE on the first registered change of {A,B,C}, with the counter cleared; Q changes alone SHALL be ignored.
REQ-024 DONE SHALL hold done=1, busy=0, and freeze err_count and seen; DONE->SETTLE on start, clearing them.
REQ-025 A start pulse in SETTLE, JUDGE or HOLD SHALL restart the run as in REQ-016.
REQ-026 busy SHALL be 1 in SETTLE, JUDGE and HOLD, and 0 otherwise.
REQ-027 mismatch SHALL be registered, asserted in the cycle after JUDGE, and never longer than one cycle.

Reset
REQ-028 Reset SHALL be synchronous and active-high, and SHALL take priority over start.
REQ-029 On rst: state=IDLE; busy=0; mismatch=0; err_count=0; seen=8'h00; done=0; counter and sample registers cleared.
REQ-030 rst asserted mid-run SHALL abandon the run, with no mismatch pulse emitted on the following cycle.

Structure
REQ-031 A shared package SHALL hold the state enumeration, the SETTLE_CYCLES default and the ERR_W default.
REQ-032 The stable-input counter SHALL be a sub-module named stable_timer (inputs: clk, rst, clear, value[2:0]; output: stable).
REQ-033 The total RTL SHALL be 120-400 lines, with no latches and no combinational paths from the inputs to the outputs.

Verification
REQ-034 Walk 000..111 with 20-cycle dwell, Q correct for expected=8'hE8 -> done=1, err_count=0, seen=8'hFF, no mismatch pulse.
REQ-035 Same walk, Q wrong for combination 101 only -> exactly one mismatch pulse, err_count=1, done=1.
REQ-036 Inputs toggle every 3 cycles with SETTLE_CYCLES=4 -> no judgement occurs, seen stays 8'h00, busy=1.
REQ-037 Q forced inverted over 20 rejudged changes with ERR_W=4 -> err_count saturates at 15.
REQ-038 rst pulsed during SETTLE of the fifth combination -> all outputs at reset values on the next cycle, IDLE until start.
REQ-039 start reissued while in DONE -> seen=8'h00, err_count=0, done=0, busy=1 on the following cycle.
